// File: rtl/fnn_pkg.sv
// Shared definitions for the FNN weight loader: header field layout,
// default weight-count limit and the loader state encoding.
// Build option: WLOADER_BIAS_EN adds the BIAS state to the encoding.
package fnn_pkg;

   localparam int unsigned MAX_WEIGHTS_DEFAULT = 1024;
   localparam int unsigned CNT_WIDTH_DEFAULT   = 16;

   // Header word layout: layer[31:24], neuron[23:16], count[15:0]
   localparam int unsigned HDR_LAYER_MSB  = 31;
   localparam int unsigned HDR_LAYER_LSB  = 24;
   localparam int unsigned HDR_NEURON_MSB = 23;
   localparam int unsigned HDR_NEURON_LSB = 16;
   localparam int unsigned HDR_COUNT_MSB  = 15;
   localparam int unsigned HDR_COUNT_LSB  = 0;

`ifdef WLOADER_BIAS_EN
   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_WEIGHTS = 2'd1,
      ST_DISCARD = 2'd2,
      ST_BIAS    = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_WEIGHTS = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;
`endif

endpackage

// File: rtl/weight_loader.sv
// Weight loader: parses header/weight/bias frames from a valid/ready
// stream and strobes each weight (and bias) out with one cycle of latency.
// Build option: WLOADER_BIAS_EN expects one bias word after each frame.
module weight_loader
   import fnn_pkg::*;
#(
   parameter int unsigned MAX_WEIGHTS = MAX_WEIGHTS_DEFAULT,
   parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        weightValid,
   output logic        biasValid,
   output logic [31:0] weightValue,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        neuron_done,
   output logic        err
);

   state_t                 state, state_n;
   logic [CNT_WIDTH-1:0]   rem, rem_n;
   logic                   weight_valid_n, done_n, err_n;
   logic [31:0]            weight_value_n, layer_n, neuron_n;
   logic                   accept;
   logic [15:0]            hdr_count_raw;
   logic                   hdr_zero, hdr_too_big, rem_last;

   assign s_ready       = en;
   assign accept        = s_valid & en;
   assign hdr_count_raw = s_data[HDR_COUNT_MSB:HDR_COUNT_LSB];
   assign hdr_zero      = (hdr_count_raw == 16'd0);
   assign hdr_too_big   = (32'(hdr_count_raw) > 32'(MAX_WEIGHTS));
   assign rem_last      = (rem == CNT_WIDTH'(1));

`ifdef WLOADER_BIAS_EN
   logic        bias_valid_n;
   logic [31:0] bias_value_n;
`else
   assign biasValid = 1'b0;
   assign biasValue = 32'd0;
`endif

   // Next-state, counter and output-register logic for one accepted word
   always_comb begin
      state_n        = state;
      rem_n          = rem;
      weight_valid_n = 1'b0;
      weight_value_n = weightValue;
      layer_n        = config_layer_num;
      neuron_n       = config_neuron_num;
      done_n         = 1'b0;
      err_n          = err;
`ifdef WLOADER_BIAS_EN
      bias_valid_n   = 1'b0;
      bias_value_n   = biasValue;
`endif
      if (accept) begin
         case (state)
            ST_HDR: begin
               layer_n  = 32'(s_data[HDR_LAYER_MSB:HDR_LAYER_LSB]);
               neuron_n = 32'(s_data[HDR_NEURON_MSB:HDR_NEURON_LSB]);
               rem_n    = CNT_WIDTH'(hdr_count_raw);
               if (hdr_zero) begin
`ifdef WLOADER_BIAS_EN
                  state_n = ST_BIAS;
`else
                  done_n  = 1'b1;
`endif
               end else if (hdr_too_big) begin
                  err_n   = 1'b1;
                  state_n = ST_DISCARD;
               end else begin
                  state_n = ST_WEIGHTS;
               end
            end
            ST_WEIGHTS: begin
               weight_valid_n = 1'b1;
               weight_value_n = s_data;
               rem_n          = rem - CNT_WIDTH'(1);
               if (rem_last) begin
`ifdef WLOADER_BIAS_EN
                  state_n = ST_BIAS;
`else
                  state_n = ST_HDR;
                  done_n  = 1'b1;
`endif
               end
            end
            ST_DISCARD: begin
`ifdef WLOADER_BIAS_EN
               // Counter reaching zero means only the bias word is left
               if (rem == CNT_WIDTH'(0)) begin
                  state_n = ST_HDR;
               end else begin
                  rem_n = rem - CNT_WIDTH'(1);
               end
`else
               rem_n = rem - CNT_WIDTH'(1);
               if (rem_last) begin
                  state_n = ST_HDR;
               end
`endif
            end
`ifdef WLOADER_BIAS_EN
            ST_BIAS: begin
               bias_valid_n = 1'b1;
               bias_value_n = s_data;
               done_n       = 1'b1;
               state_n      = ST_HDR;
            end
`endif
            default: begin
               state_n = ST_HDR;
            end
         endcase
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_HDR;
         rem               <= '0;
         weightValid       <= 1'b0;
         weightValue       <= 32'd0;
         config_layer_num  <= 32'd0;
         config_neuron_num <= 32'd0;
         neuron_done       <= 1'b0;
         err               <= 1'b0;
      end else begin
         state             <= state_n;
         rem               <= rem_n;
         weightValid       <= weight_valid_n;
         weightValue       <= weight_value_n;
         config_layer_num  <= layer_n;
         config_neuron_num <= neuron_n;
         neuron_done       <= done_n;
         err               <= err_n;
      end
   end

`ifdef WLOADER_BIAS_EN
   // Bias output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         biasValid <= 1'b0;
         biasValue <= 32'd0;
      end else begin
         biasValid <= bias_valid_n;
         biasValue <= bias_value_n;
      end
   end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: expected strobe events are queued as
// stimulus is driven and compared on the falling edge when the DUT strobes.
// Build option: WLOADER_BIAS_EN selects bias-word framing expectations.
module tb_weight_loader;

`ifdef WLOADER_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, en, s_valid, s_ready;
   logic [31:0] s_data;
   logic        weightValid, biasValid, neuron_done, err;
   logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        wv;
      logic        bv;
      logic [31:0] val;
      logic        done;
      logic [31:0] layer;
      logic [31:0] neuron;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         cur;
   logic [31:0] obs;

   weight_loader dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .weightValid       (weightValid),
      .biasValid         (biasValid),
      .weightValue       (weightValue),
      .biasValue         (biasValue),
      .config_layer_num  (config_layer_num),
      .config_neuron_num (config_neuron_num),
      .neuron_done       (neuron_done),
      .err               (err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every strobe cycle must match the oldest expected event
   always @(negedge clk) begin
      if (!rst && (weightValid || biasValid || neuron_done)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: wv=%b bv=%b done=%b wval=%h bval=%h, required no strobe",
                     weightValid, biasValid, neuron_done, weightValue, biasValue);
         end else begin
            cur = exp_q.pop_front();
            obs = weightValid ? weightValue : biasValue;
            if (weightValid !== cur.wv || biasValid !== cur.bv || neuron_done !== cur.done ||
                ((cur.wv || cur.bv) && obs !== cur.val) ||
                config_layer_num !== cur.layer || config_neuron_num !== cur.neuron) begin
               errors++;
               $display("FAIL strobe_event: got wv=%b bv=%b val=%h done=%b layer=%h neuron=%h, required wv=%b bv=%b val=%h done=%b layer=%h neuron=%h",
                        weightValid, biasValid, obs, neuron_done, config_layer_num, config_neuron_num,
                        cur.wv, cur.bv, cur.val, cur.done, cur.layer, cur.neuron);
            end
         end
      end
   end

   // Global watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [31:0] d, input bit stall);
      s_data  = d;
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      if (stall) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_ev(input logic wv, input logic bv, input logic [31:0] val,
                          input logic done, input logic [7:0] layer, input logic [7:0] neuron);
      ev_t e;
      e.wv = wv; e.bv = bv; e.val = val; e.done = done;
      e.layer = {24'd0, layer};
      e.neuron = {24'd0, neuron};
      exp_q.push_back(e);
   endtask

   task automatic frame(input logic [7:0] layer, input logic [7:0] neuron, input int n,
                        input logic [31:0] base, input logic [31:0] bias, input bit stall);
      send({layer, neuron, 16'(n)}, stall);
      if (n == 0 && !BIAS_EN) push_ev(1'b0, 1'b0, 32'd0, 1'b1, layer, neuron);
      for (int i = 0; i < n; i++) begin
         push_ev(1'b1, 1'b0, base + 32'(i), (i == n - 1) && !BIAS_EN, layer, neuron);
         send(base + 32'(i), stall);
      end
      if (BIAS_EN) begin
         push_ev(1'b0, 1'b1, bias, 1'b1, layer, neuron);
         send(bias, stall);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d events outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({weightValid, biasValid, neuron_done, err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 0000", {weightValid, biasValid, neuron_done, err});
      end
      checks++;
      if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'd0) begin
         errors++;
         $display("FAIL reset_values: got %h %h %h %h, required all zero",
                  weightValue, biasValue, config_layer_num, config_neuron_num);
      end
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, required 1", s_ready);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic_frame;
      frame(8'd3, 8'd7, 10, 32'd1, 32'h38, 1'b0);
      drain("basic");
      checks++;
      if (config_layer_num !== 32'd3 || config_neuron_num !== 32'd7) begin
         errors++;
         $display("FAIL basic_config_hold: got %h/%h, required 3/7", config_layer_num, config_neuron_num);
      end
   endtask

   task automatic test_stall_frame;
      frame(8'd3, 8'd7, 10, 32'd1, 32'h38, 1'b1);
      drain("stall");
   endtask

   task automatic test_zero_count;
      frame(8'h0A, 8'h0B, 0, 32'd0, 32'h1234_5678, 1'b0);
      drain("zero_count");
   endtask

   task automatic test_max_count;
      frame(8'd9, 8'd9, 1024, 32'h100, 32'hBEEF, 1'b0);
      drain("max_count");
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL max_count_err: got %b, required 0", err);
      end
   endtask

   task automatic test_back_to_back;
      frame(8'd8, 8'd9, 3, 32'hA000_0000, 32'h11, 1'b0);
      frame(8'd10, 8'd11, 2, 32'hB000_0000, 32'h22, 1'b0);
      drain("back_to_back");
   endtask

   task automatic test_en_hold;
      en = 1'b0;
      s_data = 32'h0505_0001;
      s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL en_hold_ready: cycle %0d got %b, required 0", i, s_ready);
         end
      end
      checks++;
      if (config_layer_num !== 32'd10) begin
         errors++;
         $display("FAIL en_hold_config: got %h, required 0000000a", config_layer_num);
      end
      s_valid = 1'b0;
      en = 1'b1;
      frame(8'd5, 8'd5, 1, 32'h77, 32'h88, 1'b0);
      drain("en_hold");
   endtask

   task automatic test_overflow;
      send(32'h0405_07D0, 1'b0);
      for (int i = 0; i < 2000 + (BIAS_EN ? 1 : 0); i++) send(32'hDEAD_0000 + 32'(i), 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL overflow_err: got %b, required 1", err);
      end
      frame(8'd1, 8'd2, 2, 32'h55, 32'h66, 1'b0);
      drain("overflow_recover");
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL overflow_sticky: got %b, required 1", err);
      end
   endtask

   task automatic test_reset_midframe;
      send(32'h0307_000A, 1'b0);
      for (int i = 0; i < 4; i++) begin
         push_ev(1'b1, 1'b0, 32'd1 + 32'(i), 1'b0, 8'd3, 8'd7);
         send(32'd1 + 32'(i), 1'b0);
      end
      drain("midframe");
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({weightValid, biasValid, neuron_done, err} !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_flags: got %b, required 0000", {weightValid, biasValid, neuron_done, err});
      end
      checks++;
      if ({weightValue, biasValue, config_layer_num, config_neuron_num} !== 128'd0) begin
         errors++;
         $display("FAIL midreset_values: got %h %h %h %h, required all zero",
                  weightValue, biasValue, config_layer_num, config_neuron_num);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      frame(8'd2, 8'd1, 3, 32'hC0, 32'hC4, 1'b0);
      drain("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_stall_frame();
      test_zero_count();
      test_max_count();
      test_back_to_back();
      test_en_hold();
      test_overflow();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
